// File: rtl/led_flash_ctrl.sv
// Front-panel LED bank: per-channel flash/hold persistence state machines with a
// lamp-test sequencer that overrides the outputs (all on, then a walking single LED).
module led_flash_ctrl #(
  parameter int unsigned NCH    = 8,
  parameter int unsigned MXCNT  = 19,
  parameter int unsigned MXSTEP = 22
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [NCH-1:0] trigger,
  input  logic [NCH-1:0] hold,
  input  logic           lamp_test,
  output logic [NCH-1:0] led,
  output logic           test_busy
);

  localparam int unsigned CNTW = MXCNT + 1;
  localparam int unsigned IDXW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FLASH = 2'd1;
  localparam logic [1:0] S_HWAIT = 2'd2;

  localparam logic [1:0] T_IDLE = 2'd0;
  localparam logic [1:0] T_ALL  = 2'd1;
  localparam logic [1:0] T_WALK = 2'd2;

  logic [NCH-1:0] trig_ff;
  logic [NCH-1:0] hold_ff;
  logic           lt_ff;
  logic           lt_ff_d;
  logic [NCH-1:0] ch_active;

  // Input capture; trigger also counts as hold so a long trigger keeps the LED lit.
  always_ff @(posedge clock) begin
    if (reset) begin
      trig_ff <= '0;
      hold_ff <= '0;
      lt_ff   <= 1'b0;
      lt_ff_d <= 1'b0;
    end else begin
      trig_ff <= trigger;
      hold_ff <= hold | trigger;
      lt_ff   <= lamp_test;
      lt_ff_d <= lt_ff;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [1:0]      state_q;
    logic [1:0]      state_d;
    logic [CNTW-1:0] cnt_q;

    // Persistence counter only runs in FLASH, so retriggers cannot restart it.
    always_ff @(posedge clock) begin
      if (reset) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= (state_q == S_FLASH) ? cnt_q + CNTW'(1) : '0;
      end
    end

    always_comb begin
      state_d = S_IDLE;
      case (state_q)
        S_IDLE:  state_d = trig_ff[i]    ? S_FLASH : S_IDLE;
        S_FLASH: state_d = cnt_q[MXCNT]  ? S_HWAIT : S_FLASH;
        S_HWAIT: state_d = hold_ff[i]    ? S_HWAIT : S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    assign ch_active[i] = (state_q != S_IDLE);
  end

  logic [1:0]        seq_q;
  logic [1:0]        seq_d;
  logic [MXSTEP-1:0] scnt_q;
  logic [MXSTEP-1:0] scnt_d;
  logic [IDXW-1:0]   idx_q;
  logic [IDXW-1:0]   idx_d;
  logic [NCH-1:0]    led_d;
  logic              busy_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      seq_q     <= T_IDLE;
      scnt_q    <= '0;
      idx_q     <= '0;
      led       <= '0;
      test_busy <= 1'b0;
    end else begin
      seq_q     <= seq_d;
      scnt_q    <= scnt_d;
      idx_q     <= idx_d;
      led       <= led_d;
      test_busy <= busy_d;
    end
  end

  // Sequencer next state; edges arriving while a test runs are ignored.
  always_comb begin
    seq_d  = seq_q;
    scnt_d = '0;
    idx_d  = idx_q;
    case (seq_q)
      T_IDLE: begin
        idx_d = '0;
        if (lt_ff && !lt_ff_d) seq_d = T_ALL;
      end
      T_ALL: begin
        if (&scnt_q) begin
          seq_d = T_WALK;
          idx_d = '0;
        end else begin
          scnt_d = scnt_q + MXSTEP'(1);
        end
      end
      T_WALK: begin
        if (&scnt_q) begin
          if (idx_q == IDXW'(NCH - 1)) begin
            seq_d = T_IDLE;
            idx_d = '0;
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
        end else begin
          scnt_d = scnt_q + MXSTEP'(1);
        end
      end
      default: begin
        seq_d = T_IDLE;
        idx_d = '0;
      end
    endcase
  end

  // Output mux: the test pattern masks the live channel states.
  always_comb begin
    led_d  = ch_active;
    busy_d = (seq_q != T_IDLE);
    case (seq_q)
      T_ALL:   led_d = '1;
      T_WALK:  led_d = NCH'(1) << idx_q;
      default: led_d = ch_active;
    endcase
  end

endmodule

// File: tb/tb_led_flash_ctrl.sv
// Directed bench for led_flash_ctrl (NCH=4, MXCNT=3, MXSTEP=2) with a per-cycle
// expectation queue drained by an independent monitor.
module tb_led_flash_ctrl;

  logic       clock;
  logic       reset;
  logic [3:0] trigger;
  logic [3:0] hold;
  logic       lamp_test;
  logic [3:0] led;
  logic       test_busy;

  typedef struct {
    logic [3:0] led;
    logic       busy;
    logic [3:0] mask;
    int         sc;
    int         k;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  led_flash_ctrl #(.NCH(4), .MXCNT(3), .MXSTEP(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .trigger   (trigger),
    .hold      (hold),
    .lamp_test (lamp_test),
    .led       (led),
    .test_busy (test_busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // One expectation per cycle: inputs driven on the falling edge, output checked after the next rising edge.
  task automatic step(input int sc, input int k, input logic rst, input logic [3:0] trg,
                      input logic [3:0] hld, input logic lt, input logic [3:0] eled,
                      input logic ebusy, input logic [3:0] emask, input bit frc);
    exp_t e;
    @(negedge clock);
    if (frc) begin
      force dut.g_ch[3].state_q = 2'b11;
      #1;
      release dut.g_ch[3].state_q;
    end
    reset     = rst;
    trigger   = trg;
    hold      = hld;
    lamp_test = lt;
    e.led  = eled;
    e.busy = ebusy;
    e.mask = emask;
    e.sc   = sc;
    e.k    = k;
    q.push_back(e);
  endtask

  // Hand-written lamp-test pattern relative to the cycle the lamp_test pulse is driven.
  function automatic logic [3:0] lt_pat(input int k);
    if (k >= 2  && k <= 5)  return 4'b1111;
    if (k >= 6  && k <= 9)  return 4'b0001;
    if (k >= 10 && k <= 13) return 4'b0010;
    if (k >= 14 && k <= 17) return 4'b0100;
    if (k >= 18 && k <= 21) return 4'b1000;
    return 4'b0000;
  endfunction

  always @(posedge clock) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_chk++;
      if (((led & e.mask) !== (e.led & e.mask)) || (test_busy !== e.busy)) begin
        n_fail++;
        $display("FAIL sc%0d k%0d: got led=%b busy=%b, want led=%b busy=%b (mask %b)",
                 e.sc, e.k, led, test_busy, e.led, e.busy, e.mask);
      end
    end
  end

  initial begin
    reset = 1'b1; trigger = '0; hold = '0; lamp_test = 1'b0;

    // sc0: reset state
    for (int k = 0; k < 4; k++)
      step(0, k, k < 2, 4'b0, 4'b0, 1'b0, 4'b0000, 1'b0, 4'b1111, 1'b0);

    // sc1: single pulse on channel 1, lit for 10 clocks after 2-clock latency
    for (int k = 0; k < 15; k++)
      step(1, k, 1'b0, (k == 0) ? 4'b0010 : 4'b0000, 4'b0, 1'b0,
           (k >= 2 && k <= 11) ? 4'b0010 : 4'b0000, 1'b0, 4'b1111, 1'b0);

    // sc2: simultaneous pulses on channels 0 and 2
    for (int k = 0; k < 15; k++)
      step(2, k, 1'b0, (k == 0) ? 4'b0101 : 4'b0000, 4'b0, 1'b0,
           (k >= 2 && k <= 11) ? 4'b0101 : 4'b0000, 1'b0, 4'b1111, 1'b0);

    // sc3: channel 2 with hold for 40 clocks and a retrigger during FLASH
    for (int k = 0; k < 46; k++)
      step(3, k, 1'b0, (k == 0 || k == 4) ? 4'b0100 : 4'b0000,
           (k < 40) ? 4'b0100 : 4'b0000, 1'b0,
           (k >= 2 && k <= 41) ? 4'b0100 : 4'b0000, 1'b0, 4'b1111, 1'b0);

    // sc4: retrigger during FLASH without hold does not lengthen the flash
    for (int k = 0; k < 15; k++)
      step(4, k, 1'b0, (k == 0 || k == 4) ? 4'b0100 : 4'b0000, 4'b0, 1'b0,
           (k >= 2 && k <= 11) ? 4'b0100 : 4'b0000, 1'b0, 4'b1111, 1'b0);

    // sc5: lamp test with an ignored second pulse at test clock 6
    for (int k = 0; k < 26; k++)
      step(5, k, 1'b0, 4'b0, 4'b0, (k == 0 || k == 6), lt_pat(k),
           (k >= 2 && k <= 21), 4'b1111, 1'b0);

    // sc6: channel 0 triggered with the test and held; live state shows right after the test
    for (int k = 0; k < 31; k++)
      step(6, k, 1'b0, (k <= 1) ? 4'b0001 : 4'b0000, (k <= 23) ? 4'b0001 : 4'b0000,
           (k == 0),
           (k >= 2 && k <= 21) ? lt_pat(k) : ((k >= 22 && k <= 25) ? 4'b0001 : 4'b0000),
           (k >= 2 && k <= 21), 4'b1111, 1'b0);

    // sc7: reset during both a lamp test and a flash
    for (int k = 0; k < 21; k++)
      step(7, k, (k == 5), (k == 0) ? 4'b0010 : 4'b0000, 4'b0, (k == 0),
           (k >= 2 && k <= 4) ? 4'b1111 : 4'b0000, (k >= 2 && k <= 4), 4'b1111, 1'b0);

    // sc8: illegal channel encoding recovers to IDLE
    for (int k = 0; k < 4; k++)
      step(8, k, 1'b0, 4'b0, 4'b0, 1'b0, 4'b0000, 1'b0,
           (k == 0) ? 4'b0111 : 4'b1111, (k == 0));

    for (int i = 0; i < 3 && q.size() > 0; i++) @(posedge clock);
    #2;
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/led_flash_ctrl.md
# led_flash_ctrl

Front-panel LED controller that owns a bank of NCH LED channels. Each channel is driven by its own flash-persistence state machine: a trigger pulse produces a fixed-width flash, and a hold input extends it. A lamp-test sequencer on top of that overrides the bank, lighting all LEDs and then walking a single lit LED across the channels. It sits between status/event strobes from the trigger logic and the LED output pins.

## Interface
- NCH, 8: number of LED channels (1..32)
- MXCNT, 19: flash persistence counter MSB; flash state lasts 2^MXCNT+1 clocks (about 13 ms at 40 MHz)
- MXSTEP, 22: lamp-test step counter width; each test phase lasts exactly 2^MXSTEP clocks
- clock  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- trigger  in  NCH  per-channel flash start; level or pulse, any width
- hold  in  NCH  per-channel hold-on; keeps the LED lit after the flash
- lamp_test  in  1  start lamp test on its rising edge
- led  out  NCH  registered LED drive, active high
- test_busy  out  1  registered; high while the lamp test is displayed

## Operation
- Inputs are registered on every clock: trig_ff <= trigger; hold_ff <= hold | trigger; lt_ff <= lamp_test; lt_ff_d <= lt_ff.
- Each channel has a state machine with states IDLE, FLASH, HWAIT and its own counter cnt of MXCNT+1 bits.
  - IDLE -> FLASH when trig_ff[i] = 1.
  - FLASH -> HWAIT when cnt[MXCNT] = 1.
  - HWAIT -> IDLE when hold_ff[i] = 0.
  - Any illegal encoding -> IDLE on the next clock.
  - cnt is cleared in every state except FLASH and increments by 1 per clock in FLASH.
  - A trigger seen while the channel is in FLASH or HWAIT does not restart cnt.
- Lamp-test sequencer has states T_IDLE, T_ALL, T_WALK; step counter scnt is MXSTEP bits and idx is ceil(log2 NCH) bits.
  - T_IDLE -> T_ALL on lt_ff & !lt_ff_d; scnt = 0.
  - T_ALL -> T_WALK when scnt is all ones; idx = 0, scnt = 0.
  - In T_WALK, when scnt is all ones: if idx = NCH-1 go to T_IDLE, otherwise idx + 1 and scnt = 0.
  - A lamp_test edge while not in T_IDLE is ignored and does not restart the test.
- Output mux, registered:
  - In T_ALL, led <= all ones.
  - In T_WALK, led <= one-hot(idx).
  - Otherwise led[i] <= (state[i] != IDLE).
  - test_busy <= (sequencer != T_IDLE).
- Channel state machines keep running during the lamp test; they are only masked at the output. When the test ends, led immediately shows the live channel states.
- Reset clears every register on the next edge: input flops, channel states to IDLE, all cnt to 0, sequencer to T_IDLE, scnt and idx to 0, led to 0, test_busy to 0. Reset mid-flash or mid-test aborts the activity and leaves no pending work.

## Timing
- Trigger latency: trigger high before edge E gives trig_ff at E, FLASH at E+1, and led high after E+2 (3 clocks).
- 1-clock trigger with hold low: led high for exactly 2^MXCNT+2 clocks (FLASH for 2^MXCNT+1 clocks, HWAIT for 1).
- With hold high: led drops 2 clocks after the first edge on which hold (and trigger) are sampled low, but never before the flash time has expired.
- Lamp-test latency: lamp_test rising before edge E gives led = all ones and test_busy = 1 after E+2.
- Lamp test length: test_busy high for exactly (NCH+1)*2^MXSTEP clocks.
- Simultaneous events: triggers on several channels in the same clock are all served independently. A trigger and a lamp_test edge in the same clock both take effect.

## Test plan
Parameters for all scenarios: NCH=4, MXCNT=3, MXSTEP=2.
- After reset, 1-clock pulse on trigger[1] -> led = 0010 starting 3 clocks later, held for 10 clocks, then 0000; other bits stay 0 throughout.
- trigger[2] pulsed with hold[2] high for 40 clocks -> led[2] rises 3 clocks after the trigger and falls 2 clocks after hold drops; a second trigger[2] during FLASH does not lengthen the flash.
- lamp_test pulse -> led = 1111 for 4 clocks, then 0001, 0010, 0100, 1000 for 4 clocks each, then 0000; test_busy high for 20 clocks. A second lamp_test pulse at clock 6 of the test has no effect.
- trigger[0] plus hold[0] held high through the lamp test -> during the test led shows only the test pattern; on the first clock after test_busy falls, led = 0001.
- reset asserted mid-test and mid-flash -> on the next clock led = 0000 and test_busy = 0; no activity resumes after reset is released.
- Force a channel state register to an illegal encoding -> the channel returns to IDLE within 1 clock and led[i] = 0 one clock later.
